// File: rtl/busarb_pkg.sv
// busarb_pkg: shared state encoding and default timeout constants for busarb
package busarb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_e;
  localparam int TMO_WIDTH_DEF  = 8;
  localparam int TMO_CYCLES_DEF = 255;
endpackage

// File: rtl/busarb.sv
// busarb: round-robin two-master arbiter for the ECO32 system bus with ack timeout
// Ports: clk/rst (sync active-high); m0_*/m1_* master side (stb, we, addr, dout in;
// din, ack, err out); bus_* slave side (stb, we, addr, dout out; din, ack in).
module busarb
  import busarb_pkg::*;
#(
  parameter int TMO_WIDTH  = TMO_WIDTH_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:2] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:2] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:2] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack
);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);
  state_e               state_q;
  logic                 last_q;
  logic [TMO_WIDTH-1:0] tmo_q;
  logic                 g0, g1, ab;
  // last_q is updated on entry to ABORT, so during ABORT it names the aborted master
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= (m0_stb && (!m1_stb || last_q)) ? GNT0 : m1_stb ? GNT1 : IDLE;
        GNT0, GNT1:
          if (bus_ack || tmo_q == TMO_LAST) begin
            state_q <= bus_ack ? IDLE : ABORT;
            last_q  <= state_q == GNT1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    g0       = state_q == GNT0;
    g1       = state_q == GNT1;
    ab       = state_q == ABORT;
    bus_stb  = g0 | g1;
    bus_we   = g0 ? m0_we : g1 ? m1_we : 1'b0;
    bus_addr = g0 ? m0_addr : g1 ? m1_addr : '0;
    bus_dout = g0 ? m0_dout : g1 ? m1_dout : '0;
    m0_din   = g0 ? bus_din : '0;
    m1_din   = g1 ? bus_din : '0;
    m0_err   = ab & ~last_q;
    m1_err   = ab & last_q;
    m0_ack   = (g0 & bus_ack) | m0_err;
    m1_ack   = (g1 & bus_ack) | m1_err;
  end
endmodule

// File: tb/tb_busarb.sv
// tb_busarb: directed self-checking bench for busarb
module tb_busarb;
  import busarb_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [31:2] m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout, m0_din, m1_din;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        bus_stb, bus_we, bus_ack;
  logic [31:2] bus_addr;
  logic [31:0] bus_dout, bus_din;
  int          checks = 0;
  int          errors = 0;
  busarb #(.TMO_WIDTH(8), .TMO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dout = '0;
    m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dout = '0;
    bus_din = '0; bus_ack = 0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_bus_stb", 32'(bus_stb), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_dout", 32'(bus_dout), 0);
    chk("rst_m0_ack", 32'(m0_ack), 0);
    chk("rst_m1_ack", 32'(m1_ack), 0);
    chk("rst_m0_err", 32'(m0_err), 0);
    chk("rst_m1_err", 32'(m1_err), 0);
    chk("rst_m0_din", m0_din, 0);
    chk("rst_m1_din", m1_din, 0);
    // single read by m0, slave acks 3 cycles after bus_stb rises
    cyc();
    m0_stb = 1; m0_we = 0; m0_addr = 30'h40;
    #1;
    chk("rd_idle_stb", 32'(bus_stb), 0);
    cyc();
    chk("rd_gnt_stb", 32'(bus_stb), 1);
    chk("rd_gnt_addr", 32'(bus_addr), 32'h40);
    chk("rd_gnt_we", 32'(bus_we), 0);
    chk("rd_wait_ack", 32'(m0_ack), 0);
    cyc();
    cyc();
    cyc();
    bus_din = 32'hDEADBEEF; bus_ack = 1;
    #1;
    chk("rd_m0_din", m0_din, 32'hDEADBEEF);
    chk("rd_m0_ack", 32'(m0_ack), 1);
    chk("rd_m0_err", 32'(m0_err), 0);
    chk("rd_m1_din", m1_din, 0);
    chk("rd_m1_ack", 32'(m1_ack), 0);
    cyc();
    m0_stb = 0; bus_ack = 0; bus_din = '0;
    #1;
    chk("rd_after_stb", 32'(bus_stb), 0);
    chk("rd_after_ack", 32'(m0_ack), 0);
    // contention after a fresh reset: grants alternate 0,1,0,1
    cyc();
    rst = 1;
    m0_stb = 1; m0_we = 1; m0_addr = 30'h111; m0_dout = 32'hA0A0A0A0;
    m1_stb = 1; m1_we = 0; m1_addr = 30'h222; m1_dout = 32'hB1B1B1B1;
    cyc();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      bus_ack = 0;
      #1;
      chk("ct_idle_stb", 32'(bus_stb), 0);
      cyc();
      bus_ack = 1;
      #1;
      chk("ct_stb", 32'(bus_stb), 1);
      chk("ct_addr", 32'(bus_addr), (i % 2 == 0) ? 32'h111 : 32'h222);
      chk("ct_we", 32'(bus_we), (i % 2 == 0) ? 1 : 0);
      chk("ct_dout", bus_dout, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      chk("ct_m0_ack", 32'(m0_ack), (i % 2 == 0) ? 1 : 0);
      chk("ct_m1_ack", 32'(m1_ack), (i % 2 == 0) ? 0 : 1);
      cyc();
    end
    m0_stb = 0; m1_stb = 0; bus_ack = 0;
    // timeout: m1 writes an unmapped address, nobody acks
    cyc();
    m1_stb = 1; m1_we = 1; m1_addr = 30'h3FFFFFFC; m1_dout = 32'hCAFEF00D;
    bus_din = 32'h12345678;
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_stb", 32'(bus_stb), 1);
      chk("to_addr", 32'(bus_addr), 32'h3FFFFFFC);
      chk("to_we", 32'(bus_we), 1);
      chk("to_m1_ack", 32'(m1_ack), 0);
      cyc();
    end
    m1_stb = 0; m0_stb = 1; m0_we = 0; m0_addr = 30'h55; bus_ack = 1;
    #1;
    chk("to_abort_stb", 32'(bus_stb), 0);
    chk("to_abort_ack", 32'(m1_ack), 1);
    chk("to_abort_err", 32'(m1_err), 1);
    chk("to_abort_din", m1_din, 0);
    chk("to_abort_m0_ack", 32'(m0_ack), 0);
    chk("to_abort_m0_err", 32'(m0_err), 0);
    cyc();
    bus_ack = 0;
    #1;
    chk("to_idle_stb", 32'(bus_stb), 0);
    chk("to_idle_ack", 32'(m1_ack), 0);
    chk("to_idle_err", 32'(m1_err), 0);
    cyc();
    bus_ack = 1; bus_din = 32'h0BADF00D;
    #1;
    chk("to_next_addr", 32'(bus_addr), 32'h55);
    chk("to_next_ack", 32'(m0_ack), 1);
    chk("to_next_err", 32'(m0_err), 0);
    chk("to_next_din", m0_din, 32'h0BADF00D);
    // ack on the 4th granted cycle beats the timeout
    cyc();
    bus_ack = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("thr_wait_ack", 32'(m0_ack), 0);
      cyc();
    end
    bus_ack = 1;
    #1;
    chk("thr_stb", 32'(bus_stb), 1);
    chk("thr_ack", 32'(m0_ack), 1);
    chk("thr_err", 32'(m0_err), 0);
    cyc();
    m0_stb = 0; bus_ack = 0;
    #1;
    chk("thr_after_state", 32'(dut.state_q), 32'(IDLE));
    chk("thr_after_err", 32'(m0_err), 0);
    // reset during GNT0
    cyc();
    m0_stb = 1; m0_addr = 30'h77;
    cyc();
    rst = 1;
    #1;
    chk("mr_gnt_stb", 32'(bus_stb), 1);
    cyc();
    rst = 0; m1_stb = 1; m1_addr = 30'h88;
    #1;
    chk("mr_stb", 32'(bus_stb), 0);
    chk("mr_m0_ack", 32'(m0_ack), 0);
    chk("mr_m0_err", 32'(m0_err), 0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    cyc();
    chk("mr_tie_state", 32'(dut.state_q), 32'(GNT0));
    chk("mr_tie_addr", 32'(bus_addr), 32'h77);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
